// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PCF and runs a single-outstanding
// request/response handshake with instruction memory.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        drop_q, drop_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = (JumpD | PCSrcD) & ~StallF;

    // Jump wins over a simultaneous taken branch.
    always_comb begin
        target = PCBranchD;
        unique case (1'b1)
            JumpD:   target = PCJumpD;
            default: target = PCBranchD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        unique case (state_q)
            S_REQ: begin
                if (ImemReady) begin
                    state_d = S_WAIT;
                    if (redirect) begin
                        pc_d   = target;
                        drop_d = 1'b1;
                    end
                end else if (redirect) begin
                    pc_d = target;
                end
            end
            S_WAIT: begin
                if (ImemRvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect) begin
                        state_d = S_REQ;
                        if (redirect) pc_d = target;
                    end else begin
                        buf_d   = ImemRdata;
                        state_d = S_READY;
                    end
                end else if (redirect) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            S_READY: begin
                if (!StallF) begin
                    pc_d    = redirect ? target : pc_plus4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        valid_d = (state_d == S_READY);
        req_d   = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign ImemReq  = req_q & reset;
    assign ImemAddr = pc_q;
    assign PCF      = pc_q;
    assign PCPlus4F = pc_plus4;
    assign ValidF   = valid_q;
    assign InstrF   = valid_q ? buf_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vector bench for fetch_unit with a hand-driven
// instruction-memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        ImemReq, ImemReady, ImemRvalid;
    logic [31:0] ImemAddr, ImemRdata;
    logic [31:0] PCF, InstrF, PCPlus4F;
    logic        ValidF;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .PCJumpD(PCJumpD),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRvalid(ImemRvalid),
        .ImemRdata(ImemRdata),
        .PCF(PCF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .ValidF(ValidF)
    );

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] pcbr;
        logic        jump;
        logic [31:0] pcj;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    localparam int N = 36;
    vec_t v [N];

    task automatic check(input string name, input logic req,
                         input logic [31:0] pc, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc4);
        n_vec++;
        if (ImemReq !== req) begin
            n_err++;
            $display("FAIL %s ImemReq got %b want %b", name, ImemReq, req);
        end
        if (ImemAddr !== pc || PCF !== pc) begin
            n_err++;
            $display("FAIL %s ImemAddr/PCF got %h/%h want %h",
                     name, ImemAddr, PCF, pc);
        end
        if (ValidF !== valid) begin
            n_err++;
            $display("FAIL %s ValidF got %b want %b", name, ValidF, valid);
        end
        if (InstrF !== instr) begin
            n_err++;
            $display("FAIL %s InstrF got %h want %h", name, InstrF, instr);
        end
        if (PCPlus4F !== pc4) begin
            n_err++;
            $display("FAIL %s PCPlus4F got %h want %h", name, PCPlus4F, pc4);
        end
    endtask

    task automatic idle_inputs();
        StallF = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = 0; PCJumpD = 0;
        ImemReady = 0; ImemRvalid = 0; ImemRdata = 0;
    endtask

    initial begin
        // stall pcsrc pcbr jump pcj rdy rv rdata | req pc valid instr pc4
        v[0]  = '{0,0,0,0,0,1,0,0,            1,0,0,0,4};
        v[1]  = '{0,0,0,0,0,0,1,32'h2008_0005,0,0,0,0,4};
        v[2]  = '{0,0,0,0,0,0,0,0,            0,0,1,32'h2008_0005,4};
        v[3]  = '{0,0,0,0,0,1,0,0,            1,4,0,0,8};
        v[4]  = '{0,0,0,0,0,0,1,32'h1111_1111,0,4,0,0,8};
        v[5]  = '{0,0,0,0,0,0,0,0,            0,4,1,32'h1111_1111,8};
        v[6]  = '{0,0,0,0,0,1,0,0,            1,8,0,0,12};
        v[7]  = '{0,0,0,0,0,0,1,32'h2222_2222,0,8,0,0,12};
        v[8]  = '{1,0,0,0,0,0,0,0,            0,8,1,32'h2222_2222,12};
        v[9]  = '{1,0,0,0,0,0,0,0,            0,8,1,32'h2222_2222,12};
        v[10] = '{1,0,0,0,0,0,0,0,            0,8,1,32'h2222_2222,12};
        v[11] = '{1,0,0,0,0,0,0,0,            0,8,1,32'h2222_2222,12};
        v[12] = '{0,0,0,0,0,0,0,0,            0,8,1,32'h2222_2222,12};
        v[13] = '{0,0,0,0,0,1,0,0,            1,12,0,0,16};
        v[14] = '{0,0,0,0,0,0,1,32'h3333_3333,0,12,0,0,16};
        v[15] = '{0,0,0,0,0,0,0,0,            0,12,1,32'h3333_3333,16};
        v[16] = '{0,0,0,0,0,1,0,0,            1,16,0,0,20};
        v[17] = '{0,1,32'h40,0,0,0,0,0,       0,16,0,0,20};
        v[18] = '{1,0,0,1,32'h600,0,0,0,      0,32'h40,0,0,32'h44};
        v[19] = '{0,0,0,0,0,0,1,32'hDEAD_BEEF,0,32'h40,0,0,32'h44};
        v[20] = '{0,0,0,0,0,1,0,0,            1,32'h40,0,0,32'h44};
        v[21] = '{0,0,0,0,0,0,1,32'h4444_4444,0,32'h40,0,0,32'h44};
        v[22] = '{0,1,32'h200,1,32'h100,0,0,0,0,32'h40,1,32'h4444_4444,32'h44};
        v[23] = '{0,1,32'h300,0,0,1,0,0,      1,32'h100,0,0,32'h104};
        v[24] = '{0,0,0,0,0,0,1,32'h5555_5555,0,32'h300,0,0,32'h304};
        v[25] = '{0,1,32'hFFFF_FFFC,0,0,0,0,0,1,32'h300,0,0,32'h304};
        v[26] = '{0,0,0,0,0,1,0,0,            1,32'hFFFF_FFFC,0,0,0};
        v[27] = '{0,0,0,0,0,0,1,32'h6666_6666,0,32'hFFFF_FFFC,0,0,0};
        v[28] = '{0,0,0,0,0,0,0,0,            0,32'hFFFF_FFFC,1,32'h6666_6666,0};
        v[29] = '{0,0,0,0,0,1,0,0,            1,0,0,0,4};
        v[30] = '{0,0,0,0,0,0,1,32'h7777_7777,0,0,0,0,4};
        v[31] = '{0,0,0,0,0,0,0,0,            0,0,1,32'h7777_7777,4};
        v[32] = '{0,0,0,0,0,1,0,0,            1,4,0,0,8};
        v[33] = '{0,1,32'h80,0,0,0,1,32'h8888_8888,0,4,0,0,8};
        v[34] = '{0,0,0,0,0,1,0,0,            1,32'h80,0,0,32'h84};
        v[35] = '{0,0,0,0,0,0,0,0,            0,32'h80,0,0,32'h84};

        idle_inputs();
        reset = 1'b0;
        #3;
        check("reset_init", 0, 0, 0, 0, 4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < N; i++) begin
            StallF     = v[i].stall;
            PCSrcD     = v[i].pcsrc;
            PCBranchD  = v[i].pcbr;
            JumpD      = v[i].jump;
            PCJumpD    = v[i].pcj;
            ImemReady  = v[i].rdy;
            ImemRvalid = v[i].rv;
            ImemRdata  = v[i].rdata;
            #1;
            check($sformatf("vec%0d", i), v[i].req, v[i].pc,
                  v[i].valid, v[i].instr, v[i].pc4);
            @(negedge clk);
        end

        // DUT is now in WAIT at PC 0x80; reset must clear it at once.
        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset_mid_wait", 0, 0, 0, 0, 4);
        @(negedge clk);
        ImemReady = 1'b1;
        #1;
        check("reset_held", 0, 0, 0, 0, 4);
        @(negedge clk);
        ImemReady = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_release", 1, 0, 0, 0, 4);
        ImemReady = 1'b1;
        @(negedge clk);
        ImemReady  = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h2008_0005;
        #1;
        check("post_reset_wait", 0, 0, 0, 0, 4);
        @(negedge clk);
        ImemRvalid = 1'b0;
        #1;
        check("post_reset_ready", 0, 0, 1, 32'h2008_0005, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS CPU.
- Owns the PC register and runs a single-outstanding request/response handshake with instruction memory.
- Presents InstrF/PCPlus4F with a valid qualifier to the IF/ID pipeline register.
- Honours hazard-unit stalls and branch/jump redirects resolved in decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on InstrF when no instruction is valid.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard-unit stall; the PC and any presented instruction hold.
- PCSrcD  in  1  taken branch resolved in decode.
- PCBranchD  in  32  branch target.
- JumpD  in  1  jump resolved in decode.
- PCJumpD  in  32  jump target.
- ImemReq  out  1  request valid.
- ImemAddr  out  32  request address (equals PCF).
- ImemReady  in  1  memory accepts the request this cycle.
- ImemRvalid  in  1  read data valid.
- ImemRdata  in  32  instruction word.
- PCF  out  32  current fetch PC.
- InstrF  out  32  fetched instruction, NOP_INSTR when ValidF=0.
- PCPlus4F  out  32  PCF+4, mod 2^32.
- ValidF  out  1  InstrF is a real instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=REQ, PCF=RESET_PC, drop=0, instruction buffer=0.
  - ValidF=0, InstrF=NOP_INSTR, PCPlus4F=RESET_PC+4.
  - ImemReq is forced to 0 while reset=0.
  - Reset asserted mid-transaction abandons all state. Instruction memory shares the same reset, so no stale response can arrive after reset.
- FSM states REQ, WAIT, READY. Exactly one request is outstanding at a time.
- REQ:
  - ImemReq=1, ImemAddr=PCF.
  - ImemReady=1 → WAIT.
  - Until accepted, a redirect may change ImemAddr on the next cycle.
- WAIT:
  - ImemReq=0.
  - On ImemRvalid with drop=0: buffer<=ImemRdata → READY.
  - On ImemRvalid with drop=1: discard the data, drop<=0 → REQ.
- READY:
  - ValidF=1, InstrF=buffer.
  - StallF=0: the instruction is consumed at this edge, PCF<=next PC → REQ.
  - StallF=1: hold state, PCF and buffer unchanged.
- Next PC:
  - JumpD → PCJumpD.
  - Else PCSrcD → PCBranchD.
  - Else PCF+4.
  - JumpD has priority over PCSrcD.
- Redirects (JumpD or PCSrcD):
  - Honoured only when StallF=0; ignored when StallF=1.
  - REQ without ImemReady: PCF<=target, stay in REQ.
  - REQ with ImemReady in the same cycle: the old-PC request is accepted, PCF<=target, drop<=1 → WAIT.
  - WAIT without ImemRvalid: PCF<=target, drop<=1. A second redirect while drop=1 updates PCF; drop stays 1.
  - WAIT with ImemRvalid in the same cycle: discard the data → REQ with PCF=target.
  - READY: PCF<=target → REQ. The buffered instruction is consumed this edge (delay-slot instruction).
- ValidF=0 in REQ and WAIT.
- Integration with the IF/ID register: En = ValidF & ~StallF, FlushD = ~ValidF & ~StallF.
- Throughput with a zero-wait memory (Ready with Req, Rvalid next cycle): one instruction per 3 cycles (REQ→WAIT→READY).
- PCPlus4F is combinational from PCF. 32-bit add, wrap 32'hFFFF_FFFC → 32'h0000_0000.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 for address 0:
  - cycle 1: ImemReq=1, ImemAddr=0.
  - cycle 3: ValidF=1, InstrF=32'h2008_0005, PCPlus4F=4.
  - next request ImemAddr=4.
- StallF=1 held 4 cycles while in READY at PC 8:
  - InstrF, PCF=8 and ValidF=1 stable throughout.
  - no ImemReq.
  - release → ImemAddr=12.
- Redirect during WAIT (PC 16, PCSrcD=1, PCBranchD=32'h40), memory Rvalid 2 cycles later with data 32'hDEAD_BEEF:
  - data discarded, ValidF stays 0.
  - next ImemAddr=32'h40.
- JumpD=1 (PCJumpD=32'h100) and PCSrcD=1 (PCBranchD=32'h200) together in READY with StallF=0 → next ImemAddr=32'h100.
- Redirect coincident with ImemReady in REQ → WAIT with drop=1; response discarded; next request at the target.
- Reset asserted while in WAIT → outputs return to reset values immediately; after release the first request is at RESET_PC.
- PCF=32'hFFFF_FFFC → PCPlus4F=0; sequential fetch next requests address 0.
